// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
//   Instruction fetch sequencer. Holds the fetch PC and drives it onto the
//   instruction ROM address. Each fetched word is captured, together with its
//   PC, into a small prefetch queue. The queue head is offered to decode
//   through a valid/ready handshake. A redirect from execute flushes the queue
//   and restarts fetch at a new PC. Fetching HALT_INSTR stops further fetches
//   until the next redirect or reset.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   enable         fetch permitted this cycle (does not gate the output side)
//   imem_addr      ROM word address (= fetch PC register)
//   imem_data      ROM read data for imem_addr, same cycle
//   out_valid      queue head valid
//   out_instr      instruction at queue head
//   out_pc         PC of out_instr
//   out_ready      decode accepts head this cycle
//   redirect_valid flush queue and restart at redirect_pc
//   redirect_pc    new fetch address
//   halted         HALT_INSTR has been queued; fetch stopped
module instr_fetch_ctrl #(
   parameter int unsigned DEPTH      = 2,        // power of two, >= 2
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   output logic        out_valid,
   output logic [15:0] out_instr,
   output logic [15:0] out_pc,
   input  logic        out_ready,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        halted
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
   } entry_t;

   typedef enum logic {
      FETCHING = 1'b0,
      HALTED   = 1'b1
   } state_t;

   entry_t        q_mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [15:0]   fetch_pc;
   state_t        state;
   state_t        state_nxt;
   logic          push;
   logic          pop;
   logic          is_halt;

   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign is_halt   = (imem_data == HALT_INSTR);
   assign imem_addr = fetch_pc;
   assign halted    = (state == HALTED);
   assign out_instr = q_mem[rd_ptr].instr;
   assign out_pc    = q_mem[rd_ptr].pc;

   // Push decision and implicit FETCHING/HALTED machine. A full queue still
   // accepts a push when the head leaves in the same cycle.
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      if (redirect_valid) begin
         state_nxt = FETCHING;
      end else if (state == FETCHING && enable &&
                   ((count < CW'(DEPTH)) || pop)) begin
         push = 1'b1;
         if (is_halt)
            state_nxt = HALTED;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= FETCHING;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (redirect_valid) begin
         // Any pop this cycle is simply accepted; the rest is discarded.
         fetch_pc <= redirect_pc;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            // PC parks on the halt word so imem_addr points at it while halted.
            if (!is_halt)
               fetch_pc <= fetch_pc + 16'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Queue storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push && !reset)
         q_mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_data};
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;
   localparam int unsigned DEPTH = 2;
   localparam logic [15:0] RESET_PC = 16'h0000;
   localparam logic [15:0] HALT = 16'hFFFF;

   logic        clk = 1'b0;
   logic        reset, enable, out_ready, redirect_valid;
   logic [15:0] redirect_pc, imem_addr, imem_data, out_instr, out_pc;
   logic        out_valid, halted;

   logic [15:0] rom [256];
   assign imem_data = rom[imem_addr[7:0]];

   always #5 clk = ~clk;

   instr_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .HALT_INSTR(HALT)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .out_ready(out_ready), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .halted(halted));

   int checks = 0;
   int errors = 0;

   // Reference model: a queue of {pc, instr}, a fetch PC and a halt flag.
   typedef struct { logic [15:0] pc; logic [15:0] instr; } ent_t;
   ent_t        mq[$];
   logic [15:0] mpc = RESET_PC;
   bit          mhalt = 0;
   logic [15:0] got[$];  // PCs accepted by decode

   always @(posedge clk) begin
      bit   mpop, mpush;
      ent_t e;
      mpop = (mq.size() > 0) && out_ready;
      if (reset) begin
         mq.delete(); mpc = RESET_PC; mhalt = 0;
      end else if (redirect_valid) begin
         if (mpop) got.push_back(mq[0].pc);
         mq.delete(); mpc = redirect_pc; mhalt = 0;
      end else begin
         mpush = enable && !mhalt && ((mq.size() < DEPTH) || mpop);
         if (mpop) begin
            got.push_back(mq[0].pc);
            void'(mq.pop_front());
         end
         if (mpush) begin
            e.pc = mpc; e.instr = rom[mpc[7:0]];
            mq.push_back(e);
            if (e.instr == HALT) mhalt = 1; else mpc = mpc + 16'd1;
         end
      end
      #1;
      checks++;
      if (out_valid !== (mq.size() > 0)) begin
         errors++; $display("FAIL model_valid t=%0t got %b exp %b", $time, out_valid, mq.size() > 0);
      end
      checks++;
      if (imem_addr !== mpc) begin
         errors++; $display("FAIL model_addr t=%0t got %h exp %h", $time, imem_addr, mpc);
      end
      checks++;
      if (halted !== mhalt) begin
         errors++; $display("FAIL model_halted t=%0t got %b exp %b", $time, halted, mhalt);
      end
      if (mq.size() > 0) begin
         checks++;
         if (out_pc !== mq[0].pc || out_instr !== mq[0].instr) begin
            errors++;
            $display("FAIL model_head t=%0t got pc %h instr %h exp pc %h instr %h",
                     $time, out_pc, out_instr, mq[0].pc, mq[0].instr);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rom_ident();
      for (int i = 0; i < 256; i++) rom[i] = 16'(i);
   endtask

   task automatic do_reset(input bit rdy);
      reset = 1; redirect_valid = 0; enable = 1; out_ready = rdy;
      cyc(1);
      reset = 0;
   endtask

   task automatic test_reset();
      rom_ident();
      reset = 1; enable = 1; out_ready = 1; redirect_valid = 0; redirect_pc = 16'h1234;
      cyc(2);
      checks++;
      if (out_valid !== 1'b0 || imem_addr !== RESET_PC || halted !== 1'b0) begin
         errors++; $display("FAIL reset_state got v=%b a=%h h=%b exp v=0 a=%h h=0",
                            out_valid, imem_addr, halted, RESET_PC);
      end
   endtask

   task automatic test_stream();
      do_reset(1);
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_instr !== 16'(i)) begin
            errors++; $display("FAIL stream_%0d got v=%b pc=%h instr=%h exp pc=%h",
                               i, out_valid, out_pc, out_instr, 16'(i));
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset(0);
      cyc(5);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0 || imem_addr !== 16'h2) begin
         errors++; $display("FAIL bp_full got v=%b pc=%h addr=%h exp v=1 pc=0 addr=2",
                            out_valid, out_pc, imem_addr);
      end
      got.delete();
      out_ready = 1;
      cyc(3);
      checks++;
      if (got.size() != 3 || got[0] !== 16'h0 || got[1] !== 16'h1 || got[2] !== 16'h2) begin
         errors++; $display("FAIL bp_drain got n=%0d exp pcs 0,1,2", got.size());
      end
   endtask

   task automatic test_redirect();
      do_reset(0);
      cyc(3);
      got.delete();
      redirect_valid = 1; redirect_pc = 16'h0040;
      cyc(1);
      redirect_valid = 0;
      checks++;
      if (out_valid !== 1'b0 || imem_addr !== 16'h0040) begin
         errors++; $display("FAIL redir_flush got v=%b addr=%h exp v=0 addr=0040", out_valid, imem_addr);
      end
      cyc(1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_instr !== 16'h0040) begin
         errors++; $display("FAIL redir_first got v=%b pc=%h exp pc=0040", out_valid, out_pc);
      end
      out_ready = 1;
      cyc(3);
      checks++;
      if (got.size() == 0 || got[0] !== 16'h0040) begin
         errors++; $display("FAIL redir_stale got n=%0d first=%h exp first=0040",
                            got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
      end
   endtask

   task automatic test_halt();
      rom_ident(); rom[5] = HALT;
      do_reset(1);
      got.delete();
      cyc(10);
      checks++;
      if (halted !== 1'b1 || imem_addr !== 16'h5 || out_valid !== 1'b0) begin
         errors++; $display("FAIL halt_stick got h=%b addr=%h v=%b exp h=1 addr=5 v=0",
                            halted, imem_addr, out_valid);
      end
      checks++;
      if (got.size() != 6 || got[5] !== 16'h5) begin
         errors++; $display("FAIL halt_delivered got n=%0d exp 6 pcs ending at 5", got.size());
      end
      redirect_valid = 1; redirect_pc = 16'h0;
      cyc(1);
      redirect_valid = 0;
      checks++;
      if (halted !== 1'b0 || imem_addr !== 16'h0) begin
         errors++; $display("FAIL halt_resume got h=%b addr=%h exp h=0 addr=0", halted, imem_addr);
      end
      cyc(2);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'h1) begin
         errors++; $display("FAIL halt_refetch got v=%b pc=%h exp v=1 pc=1", out_valid, out_pc);
      end
      cyc(8);
      rom[5] = 16'h5;
   endtask

   task automatic test_wrap();
      rom_ident();
      do_reset(1);
      redirect_valid = 1; redirect_pc = 16'hFFFE;
      cyc(1);
      redirect_valid = 0;
      for (int i = 0; i < 3; i++) begin
         logic [15:0] exp;
         exp = 16'hFFFE + 16'(i);
         cyc(1);
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp) begin
            errors++; $display("FAIL wrap_%0d got v=%b pc=%h exp pc=%h", i, out_valid, out_pc, exp);
         end
      end
   endtask

   task automatic test_reset_override();
      rom_ident(); rom[1] = HALT;
      do_reset(0);
      cyc(4);
      checks++;
      if (halted !== 1'b1 || out_valid !== 1'b1) begin
         errors++; $display("FAIL ovr_setup got h=%b v=%b exp h=1 v=1", halted, out_valid);
      end
      reset = 1; redirect_valid = 1; redirect_pc = 16'h0033;
      cyc(1);
      checks++;
      if (out_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== RESET_PC) begin
         errors++; $display("FAIL ovr_reset got v=%b h=%b addr=%h exp v=0 h=0 addr=%h",
                            out_valid, halted, imem_addr, RESET_PC);
      end
      reset = 0; redirect_valid = 0;
      rom[1] = 16'h1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 256; i++)
         rom[i] = ($urandom_range(0, 15) == 0) ? HALT : 16'($urandom_range(0, 16'hFFFE));
      do_reset(1);
      for (int c = 0; c < 600; c++) begin
         out_ready      = ($urandom_range(0, 3) != 0);
         enable         = ($urandom_range(0, 4) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = 16'($urandom);
         reset          = ($urandom_range(0, 63) == 0);
         cyc(1);
      end
      reset = 0; redirect_valid = 0;
      cyc(2);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_wrap();
      test_reset_override();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
